parity_unit: RTL and testbench

Parametrised parity generator and checker for the UART path.
- TX side: registers the parity of a parallel frame on acceptance and holds it stable for the serializer.
- RX side: accumulates sampled serial data bits LSB-first, compares them against the received parity bit, and flags errors.
- Supports four parity modes (even, odd, mark, space) and any data width.

---
 rtl/parity_pkg.sv | 26 ++
 rtl/parity_unit_if.sv | 48 ++++
 rtl/parity_rx_chk.sv | 107 ++++++++++
 rtl/parity_unit.sv | 55 +++++
 tb/tb_parity_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the UART parity unit: parity modes, RX checker states
// and the mode-to-parity-bit mapping used by both the TX and RX paths.
package parity_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'b00,
        RX_ACC      = 2'b01,
        RX_WAIT_PAR = 2'b10
    } rx_state_t;

    // xor_in is the reduction XOR of the data bits; mark/space ignore it.
    function automatic logic par_sel(input logic [1:0] mode, input logic xor_in);
        case (mode)
            PAR_EVEN: return xor_in;
            PAR_ODD:  return ~xor_in;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parity_unit_if.sv
// Bus bundle between the UART datapath and parity_unit.
// With PARITY_ERR_CNT_EN defined it also carries the error counter and its clear.
interface parity_unit_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] P_DATA;
    logic             Data_Valid;
    logic             busy;
    logic             PAR_EN;
    logic [1:0]       PAR_TYP;
    logic             par_bit;
    logic             par_vld;
    logic             rx_bit_vld;
    logic             rx_bit;
    logic             rx_par_vld;
    logic             rx_par_bit;
    logic             rx_abort;
    logic             par_err;
    logic             chk_done;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]       err_cnt;
    logic             err_cnt_clr;

    modport master (
        output P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP,
        output rx_bit_vld, rx_bit, rx_par_vld, rx_par_bit, rx_abort, err_cnt_clr,
        input  par_bit, par_vld, par_err, chk_done, err_cnt
    );

    modport slave (
        input  P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP,
        input  rx_bit_vld, rx_bit, rx_par_vld, rx_par_bit, rx_abort, err_cnt_clr,
        output par_bit, par_vld, par_err, chk_done, err_cnt
    );
`else
    modport master (
        output P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP,
        output rx_bit_vld, rx_bit, rx_par_vld, rx_par_bit, rx_abort,
        input  par_bit, par_vld, par_err, chk_done
    );

    modport slave (
        input  P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP,
        input  rx_bit_vld, rx_bit, rx_par_vld, rx_par_bit, rx_abort,
        output par_bit, par_vld, par_err, chk_done
    );
`endif

endinterface

// File: rtl/parity_rx_chk.sv
// RX parity checker: accumulates LSB-first data bits, then compares the parity bit.
// PARITY_ERR_CNT_EN adds a saturating 8-bit count of parity errors.
module parity_rx_chk
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       par_en,
    input  logic [1:0] par_typ,
    input  logic       rx_bit_vld,
    input  logic       rx_bit,
    input  logic       rx_par_vld,
    input  logic       rx_par_bit,
    input  logic       rx_abort,
`ifdef PARITY_ERR_CNT_EN
    input  logic       err_cnt_clr,
    output logic [7:0] err_cnt,
`endif
    output logic       par_err,
    output logic       chk_done
);

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             acc, acc_nxt;
    logic             err_nxt, done_nxt;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            acc      <= 1'b0;
            par_err  <= 1'b0;
            chk_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            par_err  <= err_nxt;
            chk_done <= done_nxt;
        end
    end

    // Abort wins over every strobe; in WAIT_PAR only the parity strobe matters.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (rx_abort) begin
            state_nxt = RX_IDLE;
            cnt_nxt   = '0;
            acc_nxt   = 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (rx_bit_vld) begin
                        acc_nxt   = rx_bit;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (WIDTH == 1) ? RX_WAIT_PAR : RX_ACC;
                    end
                end
                RX_ACC: begin
                    if (rx_bit_vld) begin
                        acc_nxt = acc ^ rx_bit;
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(WIDTH)) begin
                            state_nxt = RX_WAIT_PAR;
                        end
                    end
                end
                RX_WAIT_PAR: begin
                    if (rx_par_vld) begin
                        err_nxt   = par_en && (rx_par_bit != par_sel(par_typ, acc));
                        done_nxt  = 1'b1;
                        state_nxt = RX_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = RX_IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err_cnt_clr) begin
            err_cnt <= 8'd0;
        end else if (par_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/parity_unit.sv
// UART parity generator (TX, kept here) and checker (RX, in parity_rx_chk).
// Optional saturating error counter when PARITY_ERR_CNT_EN is defined.
module parity_unit
    import parity_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    parity_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic tx_accept;
    logic tx_par_nxt;

    assign tx_accept  = bus.Data_Valid && !bus.busy;
    assign tx_par_nxt = bus.PAR_EN ? par_sel(bus.PAR_TYP, ^bus.P_DATA) : 1'b0;

    // par_bit only moves on an accepted frame so the serializer sees a stable bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.par_bit <= 1'b0;
            bus.par_vld <= 1'b0;
        end else begin
            bus.par_vld <= tx_accept;
            if (tx_accept) begin
                bus.par_bit <= tx_par_nxt;
            end
        end
    end

    parity_rx_chk #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_rx_chk (
        .clk         (CLK),
        .rst_n       (RST),
        .par_en      (bus.PAR_EN),
        .par_typ     (bus.PAR_TYP),
        .rx_bit_vld  (bus.rx_bit_vld),
        .rx_bit      (bus.rx_bit),
        .rx_par_vld  (bus.rx_par_vld),
        .rx_par_bit  (bus.rx_par_bit),
        .rx_abort    (bus.rx_abort),
`ifdef PARITY_ERR_CNT_EN
        .err_cnt_clr (bus.err_cnt_clr),
        .err_cnt     (bus.err_cnt),
`endif
        .par_err     (bus.par_err),
        .chk_done    (bus.chk_done)
    );

endmodule

// File: tb/tb_parity_unit.sv
// Directed self-checking bench for parity_unit (WIDTH=8).
// Covers the error counter too when PARITY_ERR_CNT_EN is defined.
module tb_parity_unit;
    import parity_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    parity_unit_if #(.WIDTH(8)) bus ();

    parity_unit #(.WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle TX frame strobe; outputs are sampled 1ns after the capturing edge.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] typ,
                                 input logic en, input logic busy_in);
        bus.P_DATA     = data;
        bus.PAR_TYP    = typ;
        bus.PAR_EN     = en;
        bus.busy       = busy_in;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        bus.busy       = 1'b0;
    endtask

    task automatic rxFrame(input logic [7:0] data, input logic pbit, input int exp_err,
                           input string tag, input logic both);
        for (int i = 0; i < 8; i++) begin
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = data[i];
            tick();
            checkOutput({tag, "_bit_done"}, 32'(bus.chk_done), 0);
        end
        bus.rx_bit_vld = both;
        bus.rx_par_vld = 1'b1;
        bus.rx_par_bit = pbit;
        tick();
        bus.rx_bit_vld = 1'b0;
        bus.rx_par_vld = 1'b0;
        checkOutput({tag, "_done"}, 32'(bus.chk_done), 1);
        checkOutput({tag, "_err"}, 32'(bus.par_err), 32'(exp_err));
        tick();
        checkOutput({tag, "_done_clr"}, 32'(bus.chk_done), 0);
        checkOutput({tag, "_err_clr"}, 32'(bus.par_err), 0);
    endtask

    task automatic rxBits(input logic [2:0] bits);
        for (int i = 0; i < 3; i++) begin
            bus.rx_bit_vld = 1'b1;
            bus.rx_bit     = bits[i];
            tick();
        end
        bus.rx_bit_vld = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.busy       = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = PAR_EVEN;
        bus.rx_bit_vld = 1'b0;
        bus.rx_bit     = 1'b0;
        bus.rx_par_vld = 1'b0;
        bus.rx_par_bit = 1'b0;
        bus.rx_abort   = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        bus.err_cnt_clr = 1'b0;
`endif
        #12;
        checkOutput("rst_par_bit", 32'(bus.par_bit), 0);
        checkOutput("rst_par_vld", 32'(bus.par_vld), 0);
        checkOutput("rst_par_err", 32'(bus.par_err), 0);
        checkOutput("rst_chk_done", 32'(bus.chk_done), 0);
        rst_n = 1'b1;
        tick();

        // TX modes, hold and busy
        applyStimulus(8'hA5, PAR_EVEN, 1'b1, 1'b0);
        checkOutput("tx_even_bit", 32'(bus.par_bit), 0);
        checkOutput("tx_even_vld", 32'(bus.par_vld), 1);
        tick();
        checkOutput("tx_vld_pulse", 32'(bus.par_vld), 0);
        applyStimulus(8'hA5, PAR_ODD, 1'b1, 1'b0);
        checkOutput("tx_odd_bit", 32'(bus.par_bit), 1);
        applyStimulus(8'h01, PAR_EVEN, 1'b1, 1'b0);
        checkOutput("tx_even01_bit", 32'(bus.par_bit), 1);
        checkOutput("tx_even01_vld", 32'(bus.par_vld), 1);
        applyStimulus(8'h03, PAR_EVEN, 1'b1, 1'b1);
        checkOutput("tx_busy_bit", 32'(bus.par_bit), 1);
        checkOutput("tx_busy_vld", 32'(bus.par_vld), 0);
        bus.P_DATA  = 8'h03;
        bus.PAR_TYP = PAR_EVEN;
        tick();
        checkOutput("tx_hold_bit", 32'(bus.par_bit), 1);
        checkOutput("tx_hold_vld", 32'(bus.par_vld), 0);
        applyStimulus(8'hFF, PAR_SPACE, 1'b1, 1'b0);
        checkOutput("tx_space_bit", 32'(bus.par_bit), 0);
        applyStimulus(8'h00, PAR_MARK, 1'b1, 1'b0);
        checkOutput("tx_mark_bit", 32'(bus.par_bit), 1);
        applyStimulus(8'h00, PAR_MARK, 1'b0, 1'b0);
        checkOutput("tx_dis_bit", 32'(bus.par_bit), 0);
        checkOutput("tx_dis_vld", 32'(bus.par_vld), 1);

        // RX pass / fail / modes
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = PAR_EVEN;
        rxFrame(8'h5A, 1'b0, 0, "rx_pass", 1'b0);
        rxFrame(8'h5A, 1'b1, 1, "rx_fail", 1'b0);
        bus.PAR_TYP = PAR_ODD;
        rxFrame(8'h5A, 1'b1, 0, "rx_odd", 1'b0);
        bus.PAR_TYP = PAR_MARK;
        rxFrame(8'h5A, 1'b0, 1, "rx_mark", 1'b0);
        bus.PAR_TYP = PAR_EVEN;
        rxFrame(8'h5A, 1'b0, 0, "rx_both", 1'b1);

        // Stray parity strobes, then abort a partial frame
        bus.rx_par_vld = 1'b1;
        tick();
        bus.rx_par_vld = 1'b0;
        checkOutput("rx_idle_par_done", 32'(bus.chk_done), 0);
        rxBits(3'b001);
        bus.rx_par_vld = 1'b1;
        tick();
        bus.rx_par_vld = 1'b0;
        checkOutput("rx_acc_par_done", 32'(bus.chk_done), 0);
        bus.rx_abort   = 1'b1;
        bus.rx_bit_vld = 1'b1;
        bus.rx_bit     = 1'b1;
        tick();
        bus.rx_abort   = 1'b0;
        bus.rx_bit_vld = 1'b0;
        checkOutput("rx_abort_done", 32'(bus.chk_done), 0);
        checkOutput("rx_abort_err", 32'(bus.par_err), 0);
        rxFrame(8'h0F, 1'b0, 0, "rx_after_abort", 1'b0);

        bus.PAR_EN = 1'b0;
        rxFrame(8'h5A, 1'b1, 0, "rx_par_dis", 1'b0);
        bus.PAR_EN = 1'b1;

        // Asynchronous reset in the middle of an RX frame
        applyStimulus(8'h01, PAR_EVEN, 1'b1, 1'b0);
        checkOutput("pre_rst_bit", 32'(bus.par_bit), 1);
        rxBits(3'b111);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_bit", 32'(bus.par_bit), 0);
        checkOutput("async_rst_vld", 32'(bus.par_vld), 0);
        checkOutput("async_rst_done", 32'(bus.chk_done), 0);
        #3 rst_n = 1'b1;
        tick();
        rxFrame(8'hA5, 1'b0, 0, "rx_after_rst", 1'b0);

`ifdef PARITY_ERR_CNT_EN
        checkOutput("cnt_start", 32'(bus.err_cnt), 0);
        for (int n = 0; n < 300; n++) begin
            rxFrame(8'h00, 1'b1, 1, "cnt_err", 1'b0);
        end
        checkOutput("cnt_saturate", 32'(bus.err_cnt), 255);
        bus.err_cnt_clr = 1'b1;
        tick();
        bus.err_cnt_clr = 1'b0;
        checkOutput("cnt_clear", 32'(bus.err_cnt), 0);
        rxFrame(8'h00, 1'b1, 1, "cnt_one", 1'b0);
        checkOutput("cnt_after_one", 32'(bus.err_cnt), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
